fu_dispatch: RTL and testbench
==============================

# fu_dispatch

Issue-side controller for a fixed- or variable-latency functional unit that uses a one-cycle `EN` start pulse and a one-cycle `finish` completion pulse, such as the pipelined multiplier FU. It accepts operand/tag requests from the issue stage through a small FIFO. It drives the FU one operation at a time, captures the FU result on `finish`, and presents it to write-back under a valid/ready handshake. A watchdog flags an FU that never completes.

## Interface
- `TAG_W`, 5: width of destination-register tag.
- `DEPTH`, 2: request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 15: max cycles in WAIT before `timeout_err`; ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `issue_valid` in 1: request present.
- `issue_ready` out 1: FIFO not full (combinational from FIFO count).
- `issue_a` in 32: operand A.
- `issue_b` in 32: operand B.
- `issue_tag` in TAG_W: destination tag.
- `fu_en` out 1: one-cycle start pulse to FU (registered).
- `fu_a` out 32: operand A to FU (registered).
- `fu_b` out 32: operand B to FU (registered).
- `fu_finish` in 1: FU completion pulse.
- `fu_res` in 32: FU result, valid when `fu_finish`=1.
- `wb_valid` out 1: result held for write-back.
- `wb_ready` in 1: write-back accepts.
- `wb_res` out 32: captured result.
- `wb_tag` out TAG_W: tag of captured result.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- FIFO: enqueue on rising edge when `issue_valid & issue_ready`. Pointers wrap modulo `DEPTH`. A full FIFO deasserts `issue_ready`. Enqueue and dequeue in the same cycle are both honoured; the count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE → ISSUE when FIFO non-empty. On this edge, pop the head into `fu_a`/`fu_b` and the internal tag register.
  - ISSUE: `fu_en`=1 for exactly this cycle. Then → WAIT; the watchdog counter clears to 0.
  - WAIT: on `fu_finish`=1, latch `fu_res`→`wb_res` and tag→`wb_tag`, then → DONE. Otherwise increment the watchdog, saturating at `TIMEOUT`. When the count equals `TIMEOUT`, set `timeout_err`=1. It stays set until reset, and the FSM remains in WAIT.
  - DONE: `wb_valid`=1. On `wb_ready`=1 → IDLE. `wb_res`/`wb_tag` stay stable while `wb_valid`=1 and `wb_ready`=0.
- `fu_finish` outside WAIT is ignored: no capture, no state change.
- Only one FU operation is outstanding at a time. The next `fu_en` is always ≥2 cycles after the previous `finish` (DONE, then IDLE), so the FU has returned to idle.
- `fu_a`/`fu_b` hold their values from the ISSUE cycle until the next pop, which covers FUs that read operands after `EN`.
- Reset values: FIFO empty, state IDLE, `fu_en`=0, `fu_a`=`fu_b`=0, `wb_valid`=0, `wb_res`=0, `wb_tag`=0, `timeout_err`=0, `busy`=0, `issue_ready`=1.
- Reset mid-operation drops all queued and in-flight requests. Any later `fu_finish` from the aborted op arrives in IDLE and is ignored.

## Timing
- Request accepted at edge of cycle 0 → IDLE sees it in cycle 1 → `fu_en`=1 in cycle 2.
- If `fu_finish`=1 in cycle k (k≥3), then `wb_valid`=1 from cycle k+1.
- Minimum issue-to-writeback latency is 4 cycles.
- Back-to-back throughput: one op per (FU latency + 3) cycles when `wb_ready` is held high.
- `issue_ready` reflects the count at the start of the cycle. A pop in the same cycle does not raise it combinationally.

## Test plan
- Reset, then single request A=3, B=5, tag=7. The FU model pulses `finish` with `res`=15 five cycles after `fu_en`. Required: `fu_en` in cycle 2 only; `fu_a`=3, `fu_b`=5; `wb_valid` cycle after finish with `wb_res`=15, `wb_tag`=7; `busy` drops after the wb handshake.
- Three requests in consecutive cycles with `DEPTH`=2. Required: the third request sees `issue_ready`=0 until the first pop. Results exit in order with tags 1, 2, 3. No two `fu_en` pulses occur within 2 cycles of a `finish`.
- Hold `wb_ready`=0 for 10 cycles in DONE. Required: `wb_res`/`wb_tag` stay constant, no new `fu_en`, and FIFO contents are preserved. Raise `wb_ready`: the next op issues 2 cycles later.
- FU model never asserts `finish`, `TIMEOUT`=15. Required: `timeout_err`=1 exactly 15 cycles after entering WAIT, and it stays 1. A late `finish` still completes the op; the flag remains set until `rst`.
- Spurious `fu_finish` pulses while IDLE and while in DONE. Required: no change to `wb_res`, `wb_tag`, or state.
- Assert `rst` asynchronously mid-WAIT with 1 entry queued. Required: all outputs at reset values immediately. A following `finish` is ignored, and the FIFO is empty.

Source files
------------

// File: rtl/fu_dispatch_if.sv
// ----------------------------------------------------------------------------
// fu_dispatch_if
// Bundles every non-clock/reset signal of fu_dispatch.
//   issue_*  : request side (valid/ready, operands, destination tag)
//   fu_*     : start pulse and operands to the FU, completion pulse and result
//   wb_*     : write-back side (valid/ready, result, tag)
//   busy, timeout_err : status
// modport slave  : the dispatcher itself
// modport master : the environment (issue stage, FU and write-back stage)
// ----------------------------------------------------------------------------
interface fu_dispatch_if #(
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [TAG_W-1:0] issue_tag;
    logic             fu_en;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_finish;
    logic [31:0]      fu_res;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_res;
    logic [TAG_W-1:0] wb_tag;
    logic             busy;
    logic             timeout_err;

    modport slave (
        input  issue_valid, issue_a, issue_b, issue_tag, fu_finish, fu_res, wb_ready,
        output issue_ready, fu_en, fu_a, fu_b, wb_valid, wb_res, wb_tag, busy, timeout_err
    );

    modport master (
        output issue_valid, issue_a, issue_b, issue_tag, fu_finish, fu_res, wb_ready,
        input  issue_ready, fu_en, fu_a, fu_b, wb_valid, wb_res, wb_tag, busy, timeout_err
    );
endinterface

// File: rtl/fu_dispatch.sv
// ----------------------------------------------------------------------------
// fu_dispatch
// Issue-side controller for a functional unit using a one-cycle start pulse
// (fu_en) and a one-cycle completion pulse (fu_finish). Requests are queued in
// a small FIFO, issued one at a time, and the captured result is offered to
// write-back under valid/ready. A watchdog raises a sticky timeout_err when the
// FU stays silent for TIMEOUT cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fu_dispatch_if.slave (issue, FU and write-back signals, status)
// ----------------------------------------------------------------------------
module fu_dispatch #(
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    fu_dispatch_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    // FIFO storage; contents are don't-care while the FIFO is empty, so no reset
    logic [31:0]      mem_a_q   [DEPTH];
    logic [31:0]      mem_b_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t           state_q, state_d;
    logic             fu_en_q, fu_en_d;
    logic [31:0]      fu_a_q, fu_a_d;
    logic [31:0]      fu_b_q, fu_b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_res_q, wb_res_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;

    logic             full;
    logic             push;
    logic             pop;

    // issue_ready depends on the registered count only, so a pop in the same
    // cycle cannot open a slot combinationally
    assign full = (count_q == CNT_W'(DEPTH));
    assign push = bus.issue_valid && !full;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d    = state_q;
        fu_a_d     = fu_a_q;
        fu_b_d     = fu_b_q;
        tag_d      = tag_q;
        wb_res_d   = wb_res_q;
        wb_tag_d   = wb_tag_q;
        wd_d       = wd_q;
        err_d      = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    fu_a_d   = mem_a_q[rd_ptr_q];
                    fu_b_d   = mem_b_q[rd_ptr_q];
                    tag_d    = mem_tag_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.fu_finish) begin
                    wb_res_d = bus.fu_res;
                    wb_tag_d = tag_q;
                    state_d  = S_DONE;
                end else if (wd_q != WD_W'(TIMEOUT)) begin
                    // Saturating watchdog; the flag rises on the same edge the
                    // count reaches TIMEOUT and never clears outside reset
                    wd_d = wd_q + WD_W'(1);
                    if (wd_q + WD_W'(1) == WD_W'(TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are derived from the next state
        fu_en_d    = (state_d == S_ISSUE);
        wb_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]   <= bus.issue_a;
            mem_b_q[wr_ptr_q]   <= bus.issue_b;
            mem_tag_q[wr_ptr_q] <= bus.issue_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            fu_en_q    <= 1'b0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            tag_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_res_q   <= '0;
            wb_tag_q   <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            fu_en_q    <= fu_en_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            tag_q      <= tag_d;
            wb_valid_q <= wb_valid_d;
            wb_res_q   <= wb_res_d;
            wb_tag_q   <= wb_tag_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
        end
    end

    assign bus.issue_ready = !full;
    assign bus.fu_en       = fu_en_q;
    assign bus.fu_a        = fu_a_q;
    assign bus.fu_b        = fu_b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_res      = wb_res_q;
    assign bus.wb_tag      = wb_tag_q;
    assign bus.busy        = (count_q != '0) || (state_q != S_IDLE);
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_fu_dispatch.sv
// ----------------------------------------------------------------------------
// tb_fu_dispatch
// Directed bench for fu_dispatch. A transaction-level model (request queue plus
// the cycle stamps of the current operation) predicts every output each cycle;
// hand-computed literals pin the key timing points of each scenario.
// ----------------------------------------------------------------------------
module tb_fu_dispatch;
    localparam int TAG_W   = 5;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fu_dispatch_if #(.TAG_W(TAG_W)) bus ();

    fu_dispatch #(.TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Behavioural model: queue of pending requests and, for the operation
    // in flight, the cycle of its start pulse and whether it has finished.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t             mq[$];
    bit               m_op     = 1'b0;
    bit               m_fin    = 1'b0;
    int               m_cyc    = 0;
    int               m_en     = 0;
    logic [TAG_W-1:0] m_tag    = '0;
    logic [31:0]      e_fu_a   = '0;
    logic [31:0]      e_fu_b   = '0;
    logic [31:0]      e_wb_res = '0;
    logic [TAG_W-1:0] e_wb_tag = '0;
    bit               e_err    = 1'b0;

    function automatic bit m_waiting();
        return m_op && (m_cyc > m_en) && !m_fin;
    endfunction
    function automatic bit m_wb_valid();
        return m_op && m_fin;
    endfunction
    function automatic bit m_fu_en();
        return m_op && (m_cyc == m_en);
    endfunction
    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction
    function automatic bit m_busy();
        return (mq.size() != 0) || m_op;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_op     = 1'b0;
            m_fin    = 1'b0;
            m_tag    = '0;
            e_fu_a   = '0;
            e_fu_b   = '0;
            e_wb_res = '0;
            e_wb_tag = '0;
            e_err    = 1'b0;
        end else begin
            int   sz;
            bit   rdy;
            req_t r;
            sz  = mq.size();
            rdy = m_ready();
            if (m_waiting()) begin
                if (bus.fu_finish) begin
                    m_fin    = 1'b1;
                    e_wb_res = bus.fu_res;
                    e_wb_tag = m_tag;
                end else if (m_cyc - m_en >= TIMEOUT) begin
                    e_err = 1'b1;
                end
            end else if (m_wb_valid() && bus.wb_ready) begin
                m_op = 1'b0;
            end else if (!m_op && sz != 0) begin
                r      = mq.pop_front();
                e_fu_a = r.a;
                e_fu_b = r.b;
                m_tag  = r.tag;
                m_op   = 1'b1;
                m_fin  = 1'b0;
                m_en   = m_cyc + 1;
            end
            if (bus.issue_valid && rdy) begin
                r.a   = bus.issue_a;
                r.b   = bus.issue_b;
                r.tag = bus.issue_tag;
                mq.push_back(r);
            end
            m_cyc = m_cyc + 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_issue_ready", bus.issue_ready, m_ready());
        chk("m_fu_en",       bus.fu_en,       m_fu_en());
        chk("m_fu_a",        bus.fu_a,        e_fu_a);
        chk("m_fu_b",        bus.fu_b,        e_fu_b);
        chk("m_wb_valid",    bus.wb_valid,    m_wb_valid());
        chk("m_wb_res",      bus.wb_res,      e_wb_res);
        chk("m_wb_tag",      bus.wb_tag,      e_wb_tag);
        chk("m_busy",        bus.busy,        m_busy());
        chk("m_timeout_err", bus.timeout_err, e_err);
    endtask

    // ------------------------------------------------------------------
    // Stimulus state: FU model and write-back log
    // ------------------------------------------------------------------
    int               tcyc     = 0;
    int               fu_lat   = 5;
    int               fin_at   = -1;
    int               last_fin = -1;
    logic [31:0]      fu_prod  = '0;
    bit               spur     = 1'b0;
    logic [31:0]      spur_res = '0;
    logic [TAG_W-1:0] wb_tags[$];

    // One clock cycle: compare at the falling edge, then advance and drive the
    // FU model just after the rising edge.
    task automatic step();
        @(negedge clk);
        compare_model();
        if (bus.wb_valid && bus.wb_ready) begin
            $display("wb    tag=%0d res=%0h", bus.wb_tag, bus.wb_res);
            wb_tags.push_back(bus.wb_tag);
        end
        @(posedge clk);
        #1;
        tcyc++;
        if (bus.fu_en) begin
            if (last_fin >= 0) chk("en_gap", (tcyc - last_fin) >= 2, 1);
            fin_at  = (fu_lat > 0) ? tcyc + fu_lat : -1;
            fu_prod = bus.fu_a * bus.fu_b;
        end
        if (tcyc == fin_at) begin
            bus.fu_finish = 1'b1;
            bus.fu_res    = fu_prod;
            last_fin      = tcyc;
        end else if (spur) begin
            bus.fu_finish = 1'b1;
            bus.fu_res    = spur_res;
            spur          = 1'b0;
        end else begin
            bus.fu_finish = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, output int stall);
        bus.issue_valid = 1'b1;
        bus.issue_a     = a;
        bus.issue_b     = b;
        bus.issue_tag   = tag;
        stall = 0;
        while (!bus.issue_ready && stall < 100) begin
            step();
            stall++;
        end
        chk("send_accept", bus.issue_ready, 1);
        $display("issue tag=%0d a=%0h b=%0h stall=%0d", tag, a, b, stall);
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!bus.fu_en && n < 100) begin step(); n++; end
        chk("wait_en", bus.fu_en, 1);
    endtask

    task automatic wait_wb();
        int n = 0;
        while (!bus.wb_valid && n < 100) begin step(); n++; end
        chk("wait_wb", bus.wb_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin step(); n++; end
        chk("wait_idle", bus.busy, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int rel;
        int st;
        int exp_tags[4];
        exp_tags = '{20, 1, 2, 3};

        bus.issue_valid = 1'b0;
        bus.issue_a     = '0;
        bus.issue_b     = '0;
        bus.issue_tag   = '0;
        bus.fu_finish   = 1'b0;
        bus.fu_res      = '0;
        bus.wb_ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_busy",        bus.busy,        0);
        chk("rst_fu_en",       bus.fu_en,       0);
        chk("rst_wb_valid",    bus.wb_valid,    0);
        chk("rst_timeout",     bus.timeout_err, 0);
        rst = 1'b0;

        // Single request, FU latency 5
        fu_lat = 5;
        c0 = tcyc;
        send(32'd3, 32'd5, 5'd7, st);
        for (int i = 0; i < 12; i++) begin
            rel = tcyc - c0;
            chk("t1_fu_en", bus.fu_en, (rel == 2));
            if (rel == 3) begin
                chk("t1_fu_a", bus.fu_a, 3);
                chk("t1_fu_b", bus.fu_b, 5);
            end
            if (rel == 7) chk("t1_wb_valid_early", bus.wb_valid, 0);
            if (rel == 8) begin
                chk("t1_wb_valid", bus.wb_valid, 1);
                chk("t1_wb_res",   bus.wb_res,   15);
                chk("t1_wb_tag",   bus.wb_tag,   7);
                chk("t1_busy_hs",  bus.busy,     1);
            end
            if (rel == 9) chk("t1_busy_after", bus.busy, 0);
            step();
        end

        // Blocker op, then three requests on consecutive cycles
        wb_tags.delete();
        fu_lat = 6;
        send(32'd2, 32'd2, 5'd20, st);
        send(32'd1, 32'd11, 5'd1, st);
        chk("t2_stall_1", st, 0);
        send(32'd2, 32'd12, 5'd2, st);
        chk("t2_stall_2", st, 0);
        send(32'd3, 32'd13, 5'd3, st);
        chk("t2_stall_3", st, 8);
        wait_idle();
        chk("t2_count", wb_tags.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_order", wb_tags[i], exp_tags[i]);

        // Write-back stall of 10 cycles with one request still queued
        fu_lat = 3;
        bus.wb_ready = 1'b0;
        send(32'd6, 32'd7, 5'd4, st);
        send(32'd2, 32'd9, 5'd5, st);
        wait_wb();
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_res", bus.wb_res,   42);
            chk("t3_hold_tag", bus.wb_tag,   4);
            chk("t3_no_en",    bus.fu_en,    0);
            chk("t3_hold_vld", bus.wb_valid, 1);
            step();
        end
        bus.wb_ready = 1'b1;
        step();
        chk("t3_en_h1", bus.fu_en, 0);
        step();
        chk("t3_en_h2", bus.fu_en, 1);
        chk("t3_fu_a",  bus.fu_a,  2);
        chk("t3_fu_b",  bus.fu_b,  9);
        wait_wb();
        chk("t3_res2", bus.wb_res, 18);
        chk("t3_tag2", bus.wb_tag, 5);
        wait_idle();

        // Watchdog: FU never finishes, then a late finish
        fu_lat = -1;
        send(32'd1, 32'd1, 5'd6, st);
        wait_en();
        c0 = tcyc;
        for (int i = 0; i < 20; i++) begin
            step();
            rel = tcyc - c0;
            chk("t4_timeout", bus.timeout_err, (rel >= 16));
        end
        spur     = 1'b1;
        spur_res = 32'hdead_beef;
        step();
        step();
        chk("t4_late_vld", bus.wb_valid,    1);
        chk("t4_late_res", bus.wb_res,      32'hdead_beef);
        chk("t4_late_tag", bus.wb_tag,      6);
        chk("t4_err_hold", bus.timeout_err, 1);
        step();
        chk("t4_idle",     bus.busy,        0);
        chk("t4_err_sticky", bus.timeout_err, 1);

        // Spurious finish while idle and while in DONE
        spur     = 1'b1;
        spur_res = 32'h1234;
        step();
        step();
        chk("t5_idle_res", bus.wb_res,   32'hdead_beef);
        chk("t5_idle_vld", bus.wb_valid, 0);
        chk("t5_idle_bsy", bus.busy,     0);
        fu_lat = 2;
        bus.wb_ready = 1'b0;
        send(32'd4, 32'd4, 5'd10, st);
        wait_wb();
        chk("t5_res", bus.wb_res, 16);
        spur     = 1'b1;
        spur_res = 32'h5555;
        step();
        step();
        chk("t5_done_vld", bus.wb_valid, 1);
        chk("t5_done_res", bus.wb_res,   16);
        chk("t5_done_tag", bus.wb_tag,   10);
        bus.wb_ready = 1'b1;
        wait_idle();

        // Asynchronous reset mid-WAIT with one request queued
        fu_lat = -1;
        send(32'd1, 32'd2, 5'd8, st);
        send(32'd3, 32'd4, 5'd9, st);
        wait_en();
        repeat (3) step();
        chk("t6_pre_busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_issue_ready", bus.issue_ready, 1);
        chk("t6_busy",        bus.busy,        0);
        chk("t6_fu_en",       bus.fu_en,       0);
        chk("t6_fu_a",        bus.fu_a,        0);
        chk("t6_fu_b",        bus.fu_b,        0);
        chk("t6_wb_valid",    bus.wb_valid,    0);
        chk("t6_wb_res",      bus.wb_res,      0);
        chk("t6_wb_tag",      bus.wb_tag,      0);
        chk("t6_timeout",     bus.timeout_err, 0);
        step();
        rst = 1'b0;
        spur     = 1'b1;
        spur_res = 32'habc;
        step();
        step();
        chk("t6_post_vld", bus.wb_valid,    0);
        chk("t6_post_res", bus.wb_res,      0);
        chk("t6_post_bsy", bus.busy,        0);
        chk("t6_post_rdy", bus.issue_ready, 1);
        repeat (4) step();
        chk("t6_empty", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
